// File: rtl/param_acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode values, FSM state
// encoding, flag record and the flag-calculation helper.
//
// flag_calc works on operands zero-extended to MAX_W bits and is told the
// real datapath width, so one function serves every DATA_W up to MAX_W.
package param_acc_cpu_pkg;

    localparam int MAX_W = 64;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_ADDC = 4'h4;
    localparam logic [3:0] OP_NEG  = 4'h5;
    localparam logic [3:0] OP_LDA  = 4'h6;
    localparam logic [3:0] OP_LDB  = 4'h7;
    localparam logic [3:0] OP_STI  = 4'h8;
    localparam logic [3:0] OP_STC  = 4'h9;
    localparam logic [3:0] OP_LDC  = 4'hA;
    localparam logic [3:0] OP_OUTC = 4'hB;
    localparam logic [3:0] OP_OUTM = 4'hC;
    localparam logic [3:0] OP_MOVA = 4'hD;
    localparam logic [3:0] OP_MOVB = 4'hE;
    localparam logic [3:0] OP_SKZ  = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_OPERAND,
        ST_MEMRD,
        ST_OUTWAIT,
        ST_SKIP,
        ST_SKIP_OP
    } state_t;

    typedef struct packed {
        logic z;
        logic c;
    } flags_t;

    // Flags of an arithmetic op (0-5) computed from the full width+1 result.
    // Any bit at or above 'width' in the sum is the carry-out; subtractive
    // ops report borrow from the operand comparison instead.
    function automatic flags_t flag_calc(input logic [3:0]       op,
                                         input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b,
                                         input logic             cin,
                                         input int               width);
        localparam logic [MAX_W:0] ONE_W = 1;
        logic [MAX_W:0] full;
        logic [MAX_W:0] mask;
        flags_t         f;
        mask = (ONE_W << width) - ONE_W;
        full = '0;
        f    = '0;
        case (op)
            OP_ADD: begin
                full = {1'b0, a} + {1'b0, b};
                f.c  = |(full & ~mask);
            end
            OP_SUB: begin
                full = {1'b0, a} - {1'b0, b};
                f.c  = (a < b);
            end
            OP_INC: begin
                full = {1'b0, a} + ONE_W;
                f.c  = |(full & ~mask);
            end
            OP_DEC: begin
                full = {1'b0, a} - ONE_W;
                f.c  = (a == '0);
            end
            OP_ADDC: begin
                full = {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
                f.c  = |(full & ~mask);
            end
            OP_NEG: begin
                full = '0 - {1'b0, a};
                f.c  = (a != '0);
            end
            default: begin
                full = '0;
                f.c  = 1'b0;
            end
        endcase
        f.z = ((full & mask) == '0);
        return f;
    endfunction

endpackage

// File: rtl/acc_cpu_ram.sv
// Single-port synchronous scratch RAM, one-cycle read latency.
// Ports: clk; we (write enable); addr; wdata; rdata (registered read data,
// old contents on a same-cycle write).
module acc_cpu_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage is deliberately not reset so it maps onto plain RAM
    // macros; sequential state uses non-blocking assignments throughout.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/param_acc_cpu.sv
// Multi-cycle accumulator CPU with a valid/ready instruction/operand input
// stream and a valid/ready result output stream.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_data/valid/ready   instruction or operand word stream (in)
//   out_data/valid/ready  result word stream (out, backpressured)
//   flag_z, flag_c        zero and carry/borrow flags from ops 0-5
// Instruction word: op = in_data[ADDR_W+3:ADDR_W], addr = in_data[ADDR_W-1:0].
module param_acc_cpu
    import param_acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              flag_z,
    output logic              flag_c
);

    if (DATA_W < ADDR_W + 4 || DATA_W > MAX_W) begin : g_bad_width
        $error("param_acc_cpu: DATA_W must satisfy ADDR_W+4 <= DATA_W <= MAX_W");
    end

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            state, state_n;
    logic [DATA_W-1:0] a, a_n, b, b_n, c, c_n, out_data_n;
    logic              out_valid_n, flag_z_n, flag_c_n;
    logic [3:0]        pend_op, pend_op_n;
    logic [ADDR_W-1:0] pend_addr, pend_addr_n;

    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic [DATA_W-1:0] alu_res;
    flags_t            alu_flags;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    assign op     = in_data[ADDR_W+3:ADDR_W];
    assign addr   = in_data[ADDR_W-1:0];
    assign in_ready = !reset && (state == ST_FETCH   || state == ST_OPERAND ||
                                 state == ST_SKIP    || state == ST_SKIP_OP);
    assign accept = in_valid && in_ready;

    acc_cpu_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_INC:  alu_res = a + ONE;
            OP_DEC:  alu_res = a - ONE;
            OP_ADDC: alu_res = a + b + {{(DATA_W-1){1'b0}}, flag_c};
            OP_NEG:  alu_res = '0 - a;
            default: alu_res = a;
        endcase
        alu_flags = flag_calc(op, MAX_W'(a), MAX_W'(b), flag_c, DATA_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FETCH;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            pend_op   <= OP_ADD;
            pend_addr <= '0;
        end else begin
            state     <= state_n;
            a         <= a_n;
            b         <= b_n;
            c         <= c_n;
            flag_z    <= flag_z_n;
            flag_c    <= flag_c_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            pend_op   <= pend_op_n;
            pend_addr <= pend_addr_n;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a hold/idle default first, so
        // no branch can leave one unassigned and infer a latch.
        state_n     = state;
        a_n         = a;
        b_n         = b;
        c_n         = c;
        flag_z_n    = flag_z;
        flag_c_n    = flag_c;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        pend_op_n   = pend_op;
        pend_addr_n = pend_addr;
        ram_we      = 1'b0;
        ram_addr    = addr;   // LDC/OUTM read is launched at the accept edge
        ram_wdata   = c;

        case (state)
            ST_FETCH: begin
                if (accept) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADDC, OP_NEG: begin
                            c_n      = alu_res;
                            flag_z_n = alu_flags.z;
                            flag_c_n = alu_flags.c;
                        end
                        OP_LDA, OP_LDB, OP_STI: begin
                            pend_op_n   = op;
                            pend_addr_n = addr;
                            state_n     = ST_OPERAND;
                        end
                        OP_STC:  ram_we = 1'b1;
                        OP_LDC, OP_OUTM: begin
                            pend_op_n = op;
                            state_n   = ST_MEMRD;
                        end
                        OP_OUTC: begin
                            out_data_n  = c;
                            out_valid_n = 1'b1;
                            state_n     = ST_OUTWAIT;
                        end
                        OP_MOVA: a_n = c;
                        OP_MOVB: b_n = c;
                        OP_SKZ: begin
                            if (flag_z) state_n = ST_SKIP;
                        end
                        default: ;
                    endcase
                end
            end
            ST_OPERAND: begin
                ram_addr  = pend_addr;
                ram_wdata = in_data;
                if (accept) begin
                    case (pend_op)
                        OP_LDA:  a_n = in_data;
                        OP_LDB:  b_n = in_data;
                        default: ram_we = 1'b1;
                    endcase
                    state_n = ST_FETCH;
                end
            end
            ST_MEMRD: begin
                // ram_rdata holds the word addressed at the issuing edge.
                if (pend_op == OP_LDC) begin
                    c_n     = ram_rdata;
                    state_n = ST_FETCH;
                end else begin
                    out_data_n  = ram_rdata;
                    out_valid_n = 1'b1;
                    state_n     = ST_OUTWAIT;
                end
            end
            ST_OUTWAIT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = ST_FETCH;
                end
            end
            ST_SKIP: begin
                if (accept) begin
                    state_n = (op == OP_LDA || op == OP_LDB || op == OP_STI)
                              ? ST_SKIP_OP : ST_FETCH;
                end
            end
            ST_SKIP_OP: begin
                if (accept) state_n = ST_FETCH;
            end
            default: state_n = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_param_acc_cpu.sv
// Directed bench for param_acc_cpu. An instruction-level model tracks the
// architectural registers, flags, scratch memory and the role of the next
// accepted word; a negedge monitor compares flags and every output transfer
// against it, and literal expectations pin the model at key points.
module tb_param_acc_cpu;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int MOD = 1 << DW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          flag_z;
    logic          flag_c;

    param_acc_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- instruction-level model ----------------
    typedef enum {R_INSTR, R_OPER, R_SKIP, R_SKIP_OP} role_t;
    role_t   role;
    int      m_a, m_b, m_c, m_pop, m_paddr;
    bit      m_z, m_cf;
    int      m_mem [1 << AW];
    int      exp_q [$];
    int      xfer_cnt = 0;
    int      last_out = -1;
    bit      mon_en   = 1'b0;
    bit      prev_hold = 1'b0;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_cf = 0;
        role = R_INSTR;
        exp_q.delete();
        prev_hold = 1'b0;
    endtask

    task automatic model_apply(input int w);
        int op, ad, s;
        op = (w >> AW) & 15;
        ad = w & ((1 << AW) - 1);
        case (role)
            R_INSTR: begin
                case (op)
                    0: begin s = m_a + m_b;        m_c = s % MOD; m_cf = (s >= MOD); end
                    1: begin m_cf = (m_a < m_b);   m_c = (m_a - m_b + MOD) % MOD; end
                    2: begin s = m_a + 1;          m_c = s % MOD; m_cf = (s >= MOD); end
                    3: begin m_cf = (m_a == 0);    m_c = (m_a + MOD - 1) % MOD; end
                    4: begin s = m_a + m_b + int'(m_cf); m_c = s % MOD; m_cf = (s >= MOD); end
                    5: begin m_cf = (m_a != 0);    m_c = (MOD - m_a) % MOD; end
                    6, 7, 8: begin m_pop = op; m_paddr = ad; role = R_OPER; end
                    9:  m_mem[ad] = m_c;
                    10: m_c = m_mem[ad];
                    11: exp_q.push_back(m_c);
                    12: exp_q.push_back(m_mem[ad]);
                    13: m_a = m_c;
                    14: m_b = m_c;
                    15: if (m_z) role = R_SKIP;
                    default: ;
                endcase
                if (op <= 5) m_z = (m_c == 0);
            end
            R_OPER: begin
                if (m_pop == 6)      m_a = w % MOD;
                else if (m_pop == 7) m_b = w % MOD;
                else                 m_mem[m_paddr] = w % MOD;
                role = R_INSTR;
            end
            R_SKIP:    role = (op >= 6 && op <= 8) ? R_SKIP_OP : R_INSTR;
            R_SKIP_OP: role = R_INSTR;
            default:   role = R_INSTR;
        endcase
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check("flag_z", 32'(flag_z), 32'(m_z));
            check("flag_c", 32'(flag_c), 32'(m_cf));
            if (prev_hold)
                check("out_hold", {23'b0, out_valid, out_data}, {23'b0, 1'b1, prev_data});
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL out_unexpected: got 0x%0h, expected no output", out_data);
                    end else begin
                        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                    xfer_cnt++;
                    last_out  = int'(out_data);
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    prev_data = out_data;
                end
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    // ---------------- driver helpers (entered at posedge+1) ----------------
    task automatic send(input int w);
        int n;
        n = 0;
        in_data  = DW'(w);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_apply(w);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(in_ready && !out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(in_ready && !out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_list(input int words [$]);
        foreach (words[i]) send(words[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x0;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        model_reset();
        #1 reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // LDA 5, LDB 3, ADD, OUTC -> 0x08
        x0 = xfer_cnt;
        send_list('{'h60, 'h05, 'h70, 'h03, 'h00, 'hB0});
        wait_idle();
        check("t1_out", 32'(last_out), 32'h08);
        check("t1_one_xfer", 32'(xfer_cnt - x0), 32'd1);
        check("t1_z", 32'(flag_z), 32'd0);
        check("t1_c", 32'(flag_c), 32'd0);

        // 0xFF + 0x01 wraps to zero with carry
        send_list('{'h60, 'hFF, 'h70, 'h01, 'h00});
        wait_idle();
        check("t2_add_z", 32'(flag_z), 32'd1);
        check("t2_add_c", 32'(flag_c), 32'd1);
        // ADDC consumes the carry: 1+1+1
        send_list('{'h60, 'h01, 'h70, 'h01, 'h40, 'hB0});
        wait_idle();
        check("t2_addc_out", 32'(last_out), 32'h03);
        check("t2_addc_c", 32'(flag_c), 32'd0);
        // 0 - 1 borrows
        send_list('{'h60, 'h00, 'h70, 'h01, 'h10, 'hB0});
        wait_idle();
        check("t2_sub_out", 32'(last_out), 32'hFF);
        check("t2_sub_c", 32'(flag_c), 32'd1);
        // NEG of 0x01 -> 0xFF with carry
        send_list('{'h60, 'h01, 'h50, 'hB0});
        wait_idle();
        check("t2_neg_out", 32'(last_out), 32'hFF);

        // STI mem[3]=0x5A, OUTM with back-pressure
        out_ready = 1'b0;
        send_list('{'h83, 'h5A, 'hC3});
        @(negedge clk);
        check("t3_memrd_in_ready", 32'(in_ready), 32'd0);
        check("t3_memrd_valid", 32'(out_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data", 32'(out_data), 32'h5A);
            check("t3_hold_in_ready", 32'(in_ready), 32'd0);
        end
        x0 = xfer_cnt;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_after_valid", 32'(out_valid), 32'd0);
        check("t3_after_in_ready", 32'(in_ready), 32'd1);
        check("t3_one_xfer", 32'(xfer_cnt - x0), 32'd1);
        check("t3_out", 32'(last_out), 32'h5A);
        @(posedge clk); #1;

        // SKZ taken: LDA pair discarded, MOVA copies C=0, INC -> 1
        send_list('{'h60, 'hFF, 'h70, 'h01, 'h00});
        send_list('{'hF0, 'h60, 'h11, 'hD0, 'h20, 'hB0});
        wait_idle();
        check("t4_skip_out", 32'(last_out), 32'h01);
        // SKZ not taken: LDA 0x11 executes, INC -> 0x12; then MOVA, OUTC
        send_list('{'hF0, 'h60, 'h11, 'h20, 'hB0});
        wait_idle();
        check("t4_noskip_out", 32'(last_out), 32'h12);
        send_list('{'hD0, 'hB0});
        wait_idle();
        check("t4_mova_out", 32'(last_out), 32'h12);
        // single-word skip: INC discarded, C stays 0
        send_list('{'h60, 'h00, 'h70, 'h00, 'h00, 'hF0, 'h20, 'hB0});
        wait_idle();
        check("t4_skip1_out", 32'(last_out), 32'h00);

        // STC to mem[F], clobber C, LDC back
        send_list('{'h60, 'hA6, 'h20, 'h9F, 'h30, 'hAF});
        @(negedge clk);
        check("t5_memrd_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t5_fetch_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send('hB0);
        wait_idle();
        check("t5_ldc_out", 32'(last_out), 32'hA7);

        // Reset between LDA and its operand: 0x05 becomes ADD
        send('h60);
        reset = 1'b1;
        @(negedge clk);
        check("t6_in_ready_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        model_reset();
        #1 reset = 1'b0;
        send('h05);
        @(negedge clk);
        check("t6_add_z", 32'(flag_z), 32'd1);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send_list('{'h20, 'hB0});
        wait_idle();
        check("t6_a_zero", 32'(last_out), 32'h01);
        // scratch memory survives reset
        send('hCF);
        wait_idle();
        check("t6_mem_kept", 32'(last_out), 32'hA7);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
